// File: rtl/vga_console_if.sv
// rtl/vga_console_if.sv - character stream in, cell-write bus out, for vga_console
// master drives characters and observes writes; slave is the console itself.
interface vga_console_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        write_op;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;

  modport master (
    output char_valid, char_data,
    input  char_ready, write_op, bus_addr, bus_data
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, write_op, bus_addr, bus_data
  );
endinterface

// File: rtl/vga_console.sv
// rtl/vga_console.sv - text console: char FIFO, cursor tracking, screen clear, cell writes
// Optional VGA_CONSOLE_LINECLEAR_EN: blank each new row on row advance.
module vga_console #(
  parameter int HNUM       = 100,
  parameter int VNUM       = 37,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk_50M,
  input  logic         rst,
  vga_console_if.slave con,
  output logic [6:0]   cursor_col,
  output logic [5:0]   cursor_row,
  output logic         busy
);

  localparam int CELLS = HNUM * VNUM;
  localparam int AW    = ($clog2(CELLS) < 12) ? 12 : $clog2(CELLS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] QMARK = 8'h3F;

`ifdef VGA_CONSOLE_LINECLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR_ALL} state_t;
`endif

  state_t state;

  // Character FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop;
  logic [7:0]  head;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign con.char_ready = !rst && !fifo_full;
  assign push           = con.char_valid && con.char_ready;
  assign pop            = (state == IDLE) && !fifo_empty;
  assign head           = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_50M) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= con.char_data;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [6:0]    col;
  logic [5:0]    row;
  logic [5:0]    next_row;
  logic [AW-1:0] row_base, cell_addr, clr_cnt;
  logic          at_last_col, is_lf, is_cr, is_bs, is_ff, is_print;

  assign row_base    = AW'(row) * AW'(HNUM);
  assign cell_addr   = row_base + AW'(col);
  assign next_row    = (row == 6'(VNUM - 1)) ? 6'd0 : row + 6'd1;
  assign at_last_col = (col == 7'(HNUM - 1));
  assign is_lf       = (head == 8'h0A);
  assign is_cr       = (head == 8'h0D);
  assign is_bs       = (head == 8'h08);
  assign is_ff       = (head == 8'h0C);
  assign is_print    = (head >= 8'h20) && (head <= 8'h7E);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state        <= CLEAR_ALL;
      clr_cnt      <= '0;
      col          <= '0;
      row          <= '0;
      con.write_op <= 1'b0;
      con.bus_addr <= '0;
      con.bus_data <= '0;
    end else begin
      con.write_op <= 1'b0;
      case (state)
        CLEAR_ALL: begin
          con.write_op <= 1'b1;
          con.bus_addr <= 32'(clr_cnt);
          con.bus_data <= 32'(SPACE);
          if (clr_cnt == AW'(CELLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
            col     <= '0;
            row     <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`ifdef VGA_CONSOLE_LINECLEAR_EN
        CLEAR_ROW: begin
          con.write_op <= 1'b1;
          con.bus_addr <= 32'(row_base + clr_cnt);
          con.bus_data <= 32'(SPACE);
          if (clr_cnt == AW'(HNUM - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`endif
        default: begin
          if (pop) begin
            if (is_ff) begin
              state   <= CLEAR_ALL;
              clr_cnt <= '0;
            end else if (is_lf) begin
              col <= '0;
              row <= next_row;
`ifdef VGA_CONSOLE_LINECLEAR_EN
              state   <= CLEAR_ROW;
              clr_cnt <= '0;
`endif
            end else if (is_cr) begin
              col <= '0;
            end else if (is_bs) begin
              if (col != 7'd0) begin
                col          <= col - 7'd1;
                con.write_op <= 1'b1;
                con.bus_addr <= 32'(cell_addr - AW'(1));
                con.bus_data <= 32'(SPACE);
              end
            end else begin
              // Control codes outside the handled set print as '?' so data never drops below 0x20.
              con.write_op <= 1'b1;
              con.bus_addr <= 32'(cell_addr);
              con.bus_data <= 32'(is_print ? head : QMARK);
              if (at_last_col) begin
                col <= '0;
                row <= next_row;
`ifdef VGA_CONSOLE_LINECLEAR_EN
                state   <= CLEAR_ROW;
                clr_cnt <= '0;
`endif
              end else begin
                col <= col + 7'd1;
              end
            end
          end
        end
      endcase
    end
  end

  assign cursor_col = col;
  assign cursor_row = row;
  assign busy       = (state != IDLE) || !fifo_empty;

endmodule
